// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared opcode/funct3 encodings, FSM state type and control-word layout.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
//
// Imported by mc_ctrl_fsm and mc_branch_eval.
package mc_ctrl_fsm_pkg;

  // RV32I base opcodes accepted by the sequencer
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // PC source select
  localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PC_SRC_REL = 2'b01;  // pc + imm
  localparam logic [1:0] PC_SRC_REG = 2'b10;  // (rs1 + imm) & ~1

  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    STATE_FETCH,
    STATE_DECODE,
    STATE_EXEC,
    STATE_MEM,
    STATE_WB,
    STATE_TRAP
  } state_e;

  // Registered control word. br_eval and st_exit mark phases whose final
  // pc_src / pc_write depend on same-cycle inputs (ALU flags, mem_ready).
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       instr_done;
    logic       br_eval;
    logic       st_exit;
  } ctl_t;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Control word for the cycle spent in state s, given the instruction's
  // opcode and funct3.
  function automatic ctl_t ctl_decode(input state_e s, input logic [6:0] op,
                                      input logic [2:0] f3);
    ctl_t c;
    c = '0;
    case (s)
      STATE_FETCH: begin
        c.mem_req  = 1'b1;
        c.mem_size = MEM_SIZE_WORD;
      end
      STATE_EXEC: begin
        case (op)
          OP_BRANCH: begin
            c.pc_write   = 1'b1;
            c.br_eval    = 1'b1;
            c.instr_done = 1'b1;
          end
          OP_JAL, OP_JALR: begin
            c.reg_write  = 1'b1;
            c.pc_write   = 1'b1;
            c.pc_src     = (op == OP_JAL) ? PC_SRC_REL : PC_SRC_REG;
            c.instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      STATE_MEM: begin
        c.mem_req      = 1'b1;
        c.mem_we       = (op == OP_STORE);
        c.mem_size     = f3[1:0];
        c.mem_unsigned = f3[2];
        c.st_exit      = (op == OP_STORE);
      end
      STATE_WB: begin
        c.reg_write  = 1'b1;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_branch_eval.sv
// Branch-taken evaluation from funct3 and ALU compare flags.
// Latency: combinational.
// Backpressure: none.
//
// Ports: funct3 (branch kind), zero/lt/ltu (ALU flags) -> taken.
module mc_branch_eval
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = !zero;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;  // 010/011 never branch
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB, sticky TRAP.
// Latency: branch/jump 3, ALU 4, store 4, load 5 cycles with mem_ready=1.
// Backpressure: FETCH/MEM hold on mem_ready; MEM_TIMEOUT idle cycles -> TRAP.
//
// Ports: clk/rst (sync, active-high); opcode/funct3 from IR; zero/lt/ltu
// from ALU; mem_ready from memory. Outputs drive PC/IR/regfile enables,
// the memory request, retire pulse, sticky illegal/bus_err flags.
// Optional macro MC_PERF_CNT_EN enables cycle_cnt/instret_cnt counters.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic             mem_unsigned,
  output logic             instr_done,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  // Wait counter holds 0..MEM_TIMEOUT-1; the wait that would reach
  // MEM_TIMEOUT traps instead of counting.
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e            state;
  state_e            nxt;
  ctl_t              ctl_q;
  ctl_t              ctl_nxt;
  logic [6:0]        op_q;
  logic [2:0]        f3_q;
  logic [6:0]        op_sel;
  logic [2:0]        f3_sel;
  logic [WAIT_W-1:0] wait_cnt;
  logic              illegal_q;
  logic              bus_err_q;
  logic              mem_ack;
  logic              timeout_hit;
  logic              taken;

  mc_branch_eval u_branch_eval (
    .funct3 (f3_q),
    .zero   (zero),
    .lt     (lt),
    .ltu    (ltu),
    .taken  (taken)
  );

  // A handshake only counts while a request is actually being driven; this
  // also keeps the post-reset idle cycle from consuming a stray mem_ready.
  assign mem_ack     = ctl_q.mem_req && mem_ready;
  assign timeout_hit = (MEM_TIMEOUT != 0) && ctl_q.mem_req && !mem_ready &&
                       (wait_cnt == WAIT_LAST);

  // The DECODE exit is the only transition that needs the live IR fields;
  // later phases use the copy latched at DECODE.
  assign op_sel = (state == STATE_DECODE) ? opcode : op_q;
  assign f3_sel = (state == STATE_DECODE) ? funct3 : f3_q;

  always_comb begin
    nxt = state;
    case (state)
      STATE_FETCH: begin
        if (mem_ack)          nxt = STATE_DECODE;
        else if (timeout_hit) nxt = STATE_TRAP;
      end
      STATE_DECODE: nxt = op_legal(opcode) ? STATE_EXEC : STATE_TRAP;
      STATE_EXEC: begin
        case (op_q)
          OP_BRANCH, OP_JAL, OP_JALR: nxt = STATE_FETCH;
          OP_LOAD, OP_STORE:          nxt = STATE_MEM;
          default:                    nxt = STATE_WB;
        endcase
      end
      STATE_MEM: begin
        if (mem_ack)          nxt = (op_q == OP_LOAD) ? STATE_WB : STATE_FETCH;
        else if (timeout_hit) nxt = STATE_TRAP;
      end
      STATE_WB: nxt = STATE_FETCH;
      default:  nxt = STATE_TRAP;
    endcase
  end

  // Control word is registered alongside the state so every Moore output
  // comes straight from a flop.
  assign ctl_nxt = ctl_decode(nxt, op_sel, f3_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STATE_FETCH;
      ctl_q     <= '0;
      op_q      <= '0;
      f3_q      <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state <= nxt;
      ctl_q <= ctl_nxt;
      if (state == STATE_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
        if (!op_legal(opcode)) illegal_q <= 1'b1;
      end
      if (nxt != state)
        wait_cnt <= '0;
      else if (ctl_q.mem_req && !mem_ready)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end

  // Store completion retires on the ready cycle itself.
  assign pc_write     = ctl_q.pc_write || (ctl_q.st_exit && mem_ready);
  assign instr_done   = ctl_q.instr_done || (ctl_q.st_exit && mem_ready);
  assign pc_src       = ctl_q.br_eval ? (taken ? PC_SRC_REL : PC_SRC_SEQ)
                                      : ctl_q.pc_src;
  assign ir_write     = mem_ack && (state == STATE_FETCH);
  assign reg_write    = ctl_q.reg_write;
  assign mem_req      = ctl_q.mem_req;
  assign mem_we       = ctl_q.mem_we;
  assign mem_size     = ctl_q.mem_size;
  assign mem_unsigned = ctl_q.mem_unsigned;
  assign illegal      = illegal_q;
  assign bus_err      = bus_err_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  // The FETCH cycle without a request is the recovery cycle after reset and
  // is treated as part of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != STATE_TRAP && !(state == STATE_FETCH && !ctl_q.mem_req))
        cycle_q <= cycle_q + CNT_W'(1);
      if (instr_done)
        instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm.
// Each cycle: drive inputs 1ns after posedge, compare outputs 3ns after posedge.
// Output vector: {pc_write, pc_src, ir_write, reg_write, mem_req, mem_we,
//                 mem_size, mem_unsigned, instr_done, illegal, bus_err}.
module tb_mc_ctrl_fsm;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             zero, lt, ltu;
  logic             mem_ready;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write, reg_write, mem_req, mem_we;
  logic [1:0]       mem_size;
  logic             mem_unsigned, instr_done, illegal, bus_err;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mc_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .funct3       (funct3),
    .zero         (zero),
    .lt           (lt),
    .ltu          (ltu),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .instr_done   (instr_done),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {pc_write, pc_src, ir_write, reg_write, mem_req, mem_we,
                mem_size, mem_unsigned, instr_done, illegal, bus_err};

  function automatic logic [12:0] ex(input logic pcw, input logic [1:0] src,
                                     input logic irw, input logic rw,
                                     input logic req, input logic we,
                                     input logic [1:0] sz, input logic uns,
                                     input logic done, input logic ill,
                                     input logic berr);
    return {pcw, src, irw, rw, req, we, sz, uns, done, ill, berr};
  endfunction

  // Compare this cycle's outputs, then advance to 1ns after the next edge.
  task automatic cyc(input string tag, input logic [12:0] expv);
    #2;
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: outputs got %013b expected %013b", tag, obs, expv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  logic [12:0] X_IDLE, X_FETCH, X_FWAIT, X_WB;

  task automatic fetch_decode(input string tag);
    mem_ready = 1'b1;
    cyc({tag, "/fetch"}, X_FETCH);
    cyc({tag, "/decode"}, X_IDLE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    X_IDLE  = '0;
    X_FETCH = ex(0, 2'b00, 1, 0, 1, 0, 2'b10, 0, 0, 0, 0);
    X_FWAIT = ex(0, 2'b00, 0, 0, 1, 0, 2'b10, 0, 0, 0, 0);
    X_WB    = ex(1, 2'b00, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0);

    rst = 1'b1; opcode = '0; funct3 = '0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", X_IDLE);
    rst = 1'b0;
    cyc("post_reset_idle", X_IDLE);

    // Ten back-to-back ADDs, 4 cycles each
    opcode = 7'b0110011; funct3 = 3'b000; mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc("add/fetch", X_FETCH);
      cyc("add/decode", X_IDLE);
      cyc("add/exec", X_IDLE);
      cyc("add/wb", X_WB);
    end
`ifdef MC_PERF_CNT_EN
    chk("cycle_cnt_10add", cycle_cnt, 32'd40);
    chk("instret_cnt_10add", instret_cnt, 32'd10);
`else
    chk("cycle_cnt_off", cycle_cnt, 32'd0);
    chk("instret_cnt_off", instret_cnt, 32'd0);
`endif

    // Branches and jumps: retire in EXEC
    opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    fetch_decode("beq_taken");
    cyc("beq_taken/exec", ex(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0));
    zero = 1'b0;
    fetch_decode("beq_not");
    cyc("beq_not/exec", ex(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0));
    funct3 = 3'b110; ltu = 1'b1;
    fetch_decode("bltu_taken");
    cyc("bltu_taken/exec", ex(1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0));
    funct3 = 3'b101; lt = 1'b1; ltu = 1'b0;
    fetch_decode("bge_not");
    cyc("bge_not/exec", ex(1, 2'b00, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0));
    lt = 1'b0;
    opcode = 7'b1101111; funct3 = 3'b000;
    fetch_decode("jal");
    cyc("jal/exec", ex(1, 2'b01, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0));
    opcode = 7'b1100111;
    fetch_decode("jalr");
    cyc("jalr/exec", ex(1, 2'b10, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0));

    // LH with three wait cycles in MEM: 8 cycles total
    opcode = 7'b0000011; funct3 = 3'b001;
    fetch_decode("lh");
    mem_ready = 1'b0;
    cyc("lh/exec", X_IDLE);
    for (int i = 0; i < 3; i++)
      cyc("lh/mem_wait", ex(0, 2'b00, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0));
    mem_ready = 1'b1;
    cyc("lh/mem_ready", ex(0, 2'b00, 0, 0, 1, 0, 2'b01, 0, 0, 0, 0));
    cyc("lh/wb", X_WB);

    // SB: retires on the MEM ready cycle, no register write
    opcode = 7'b0100011; funct3 = 3'b000;
    fetch_decode("sb");
    cyc("sb/exec", X_IDLE);
    cyc("sb/mem", ex(1, 2'b00, 0, 0, 1, 1, 2'b00, 0, 1, 0, 0));

    // Fetch never answered: 16 wait cycles, then bus error trap
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      cyc("timeout/fetch_wait", X_FWAIT);
    cyc("timeout/trap", ex(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("timeout/trap_hold", ex(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    rst = 1'b1;
    cyc("timeout/rst_cycle", ex(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    rst = 1'b0;
    cyc("timeout/cleared", X_IDLE);

    // Illegal opcode: sticky trap until reset
    opcode = 7'h7F; funct3 = 3'b000;
    fetch_decode("illegal");
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      cyc("illegal/trap_hold", ex(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    end
    rst = 1'b1;
    cyc("illegal/rst_cycle", ex(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
    rst = 1'b0;
    cyc("illegal/cleared", X_IDLE);
    opcode = 7'b0110011; mem_ready = 1'b1;
    cyc("after_rst/fetch", X_FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
